// File: rtl/tx_eight_ten_arb_pkg.sv
// Shared definitions for the 8b/10b transmitter arbiter: FSM encoding,
// default parameter values and the shared-counter sizing helper.
package tx_eight_ten_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_GAP_CYC  = 16;
  localparam int DEF_START_TO = 255;
  localparam int BYTE_W       = 8;
  localparam int BAUD_W       = 20;

  // One counter serves both the launch timeout and the inter-frame gap.
  function automatic int cnt_width(input int start_to, input int gap_cyc);
    int m;
    m = (start_to > gap_cyc) ? start_to : gap_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tx_eight_ten_arb_rr_pick.sv
// Round-robin requester picker: first set req bit after last_id, wrapping.
module rr_pick
  import tx_eight_ten_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_id,
  output logic [IW-1:0]    grant_id,
  output logic             any
);

  int idx;

  // Scan from farthest to nearest so the closest candidate after last_id wins.
  always_comb begin
    grant_id = '0;
    any      = |req;
    idx      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_id) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[IW-1:0]]) grant_id = idx[IW-1:0];
    end
  end

endmodule

// File: rtl/tx_eight_ten_arb.sv
// Arbitrates N_REQ byte requesters onto one 8b/10b transmitter, with launch
// handshake on tx_en, a sticky launch-timeout flag and an enforced idle gap.
module tx_eight_ten_arb
  import tx_eight_ten_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int START_TO = DEF_START_TO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [BYTE_W*N_REQ-1:0]    din_flat,
  input  logic [BAUD_W-1:0]          baud_in,
  input  logic                       err_clr,
  input  logic                       tx_en,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   cur_id,
  output logic [BYTE_W-1:0]          tx_din,
  output logic                       tx_sel,
  output logic                       tx_set,
  output logic [BAUD_W-1:0]          tx_baud,
  output logic                       err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(START_TO, GAP_CYC);
  localparam logic [CW-1:0] TO_LAST  = CW'((START_TO > 0) ? START_TO - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       last_id_q, last_id_d;
  logic [IW-1:0]       cur_id_q, cur_id_d;
  logic [BYTE_W-1:0]   tx_din_q, tx_din_d;
  logic [BAUD_W-1:0]   tx_baud_q, tx_baud_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;

  logic [IW-1:0]       grant_id;
  logic                any;
  logic [BYTE_W-1:0]   grant_byte;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req      (req),
    .last_id  (last_id_q),
    .grant_id (grant_id),
    .any      (any)
  );

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IW'(i)) grant_byte = din_flat[BYTE_W*i +: BYTE_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    cur_id_d  = cur_id_q;
    tx_din_d  = tx_din_q;
    tx_baud_d = tx_baud_q;
    cnt_d     = '0;
    ack_d     = '0;
    err_d     = err_clr ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          cur_id_d  = grant_id;
          tx_din_d  = grant_byte;
          tx_baud_d = baud_in;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx_en) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          // Timeout still advances last_id so a dead requester cannot starve others.
          err_d     = 1'b1;
          last_id_d = cur_id_q;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_en) begin
          ack_d[cur_id_q] = 1'b1;
          last_id_d       = cur_id_q;
          state_d         = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_id_q <= IW'(N_REQ - 1);
      cur_id_q  <= '0;
      tx_din_q  <= '0;
      tx_baud_q <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      cur_id_q  <= cur_id_d;
      tx_din_q  <= tx_din_d;
      tx_baud_q <= tx_baud_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign busy    = (state_q != S_IDLE);
  assign tx_set  = (state_q == S_START);
  assign tx_sel  = (state_q == S_START) || (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
  assign ack     = ack_q;
  assign cur_id  = cur_id_q;
  assign tx_din  = tx_din_q;
  assign tx_baud = tx_baud_q;
  assign err     = err_q;

endmodule
